// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter granting two requesters access to a 5-byte UART frame transmitter.
// Optional BUSY watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_frame_arbiter #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [39:0] data0,
    input  logic        req1,
    input  logic [39:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [1:0]  gnt,
    output logic        tx_go,
    output logic [39:0] tx_data,
    input  logic        tx_done,
    output logic        tx_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        go_q, go_d;
    logic [39:0] data_q, data_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err_q, err_d;
    logic [15:0] gap_q, gap_d;
    logic        ptr_q, ptr_d;
    logic        pick1;
    logic        gap_last;

    // ptr names the last owner; on a tie the other requester wins
    assign pick1 = req1 && (!req0 || !ptr_q);

    // The IDLE arbitration cycle is the last idle cycle of the gap
    assign gap_last = (32'(gap_q) + 32'd2) >= GAP_CYCLES;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout;

    assign timeout = (wd_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            go_q    <= 1'b0;
            data_q  <= 40'h0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            gap_q   <= 16'd0;
            ptr_q   <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            wd_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            go_q    <= go_d;
            data_q  <= data_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        go_d    = go_q;
        data_d  = data_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    data_d  = pick1 ? data1 : data0;
                    go_d    = 1'b1;
                    state_d = BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    wd_d    = 32'd0;
`endif
                end
            end
            BUSY: begin
                if (tx_done) begin
                    go_d    = 1'b0;
                    gnt_d   = 2'b00;
                    ack0_d  = gnt_q[0];
                    ack1_d  = gnt_q[1];
                    ptr_d   = gnt_q[1];
                    gap_d   = 16'd0;
                    state_d = GAP;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (timeout) begin
                    go_d    = 1'b0;
                    gnt_d   = 2'b00;
                    err_d   = 1'b1;
                    ptr_d   = gnt_q[1];
                    gap_d   = 16'd0;
                    state_d = GAP;
                end else begin
                    wd_d    = wd_q + 32'd1;
`endif
                end
            end
            GAP: begin
                if (gap_last) begin
                    gap_d   = 16'd0;
                    state_d = IDLE;
                end else begin
                    gap_d   = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign tx_go   = go_q;
    assign tx_data = data_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: grants and completions are queued
// by the stimulus and popped by a negedge monitor.
module tb_uart_frame_arbiter;

    localparam int unsigned G  = 4;
    localparam int unsigned TO = 50;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        req0    = 1'b0;
    logic        req1    = 1'b0;
    logic        tx_done = 1'b0;
    logic [39:0] data0   = 40'h0;
    logic [39:0] data1   = 40'h0;
    logic        ack0, ack1, tx_go, tx_err;
    logic [1:0]  gnt;
    logic [39:0] tx_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [39:0] data;
    } gexp_t;

    gexp_t      gq[$];
    logic [2:0] cq[$];
    gexp_t      cur;
    logic [2:0] cexp;
    bit         have = 1'b0;
    logic       go_q = 1'b0;

    always #5 sys_clk = ~sys_clk;

    uart_frame_arbiter #(
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .req0    (req0),
        .data0   (data0),
        .req1    (req1),
        .data1   (data1),
        .ack0    (ack0),
        .ack1    (ack1),
        .gnt     (gnt),
        .tx_go   (tx_go),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .tx_err  (tx_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on tx_go rise and on any completion pulse
    always @(negedge sys_clk) begin
        if (tx_go && !go_q) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant: unexpected gnt=%b data=%h", gnt, tx_data);
            end else begin
                cur  = gq.pop_front();
                have = 1'b1;
            end
        end
        if (!tx_go)
            have = 1'b0;
        if (tx_go && have) begin
            chk("gnt", 64'(gnt), 64'(cur.gnt));
            chk("tx_data", 64'(tx_data), 64'(cur.data));
        end
        if (ack0 || ack1 || tx_err) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL completion: unexpected ack1,ack0,err=%b%b%b got, none expected",
                         ack1, ack0, tx_err);
            end else begin
                cexp = cq.pop_front();
                chk("completion", 64'({ack1, ack0, tx_err}), 64'(cexp));
            end
        end
        go_q = tx_go;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_go(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (tx_go)
                return;
            n++;
        end
        checks++;
        errors++;
        $display("FAIL wait_go: tx_go never rose within 200 cycles");
    endtask

    initial begin
        int n;
        int hi;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        @(negedge sys_clk);
        chk("rst_tx_go", 64'(tx_go), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_ack0", 64'(ack0), 64'd0);
        chk("rst_ack1", 64'(ack1), 64'd0);
        chk("rst_tx_err", 64'(tx_err), 64'd0);
        tick();
        rst = 1'b0;

        // Basic frame from requester 0
        data0 = 40'h10_08_04_02_01;
        req0  = 1'b1;
        gq.push_back('{2'b01, 40'h10_08_04_02_01});
        wait_go(n);
        chk("grant_latency", 64'(n), 64'd1);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        cq.push_back(3'b010);
        pulse_done();
        @(negedge sys_clk);
        chk("done_go_low", 64'(tx_go), 64'd0);
        chk("done_gnt_clear", 64'(gnt), 64'd0);

        // Stray tx_done in GAP and in IDLE
        tick();
        pulse_done();
        repeat (4) tick();
        pulse_done();
        @(negedge sys_clk);
        chk("idle_done_go", 64'(tx_go), 64'd0);
        chk("idle_done_gnt", 64'(gnt), 64'd0);

        // Reset three cycles into BUSY; pointer returns to favour req0
        tick();
        data1 = 40'h55_44_33_22_11;
        req1  = 1'b1;
        gq.push_back('{2'b10, 40'h55_44_33_22_11});
        wait_go(n);
        chk("grant1_latency", 64'(n), 64'd1);
        tick();
        req1 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_busy_go", 64'(tx_go), 64'd0);
        chk("rst_busy_gnt", 64'(gnt), 64'd0);
        chk("rst_busy_ack", 64'({ack1, ack0, tx_err}), 64'd0);
        data0 = 40'h01_23_45_67_89;
        req0  = 1'b1;
        req1  = 1'b1;
        gq.push_back('{2'b01, 40'h01_23_45_67_89});
        wait_go(n);
        tick();
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        cq.push_back(3'b010);
        pulse_done();

        // Requester 1 pulses; its data changes mid-frame
        repeat (6) tick();
        data1 = 40'hAA_BB_CC_DD_EE;
        req1  = 1'b1;
        gq.push_back('{2'b10, 40'hAA_BB_CC_DD_EE});
        tick();
        req1  = 1'b0;
        data1 = 40'h12_34_56_78_9A;
        wait_go(n);
        tick();
        data1 = 40'hFF_00_FF_00_FF;
        tick();
        cq.push_back(3'b100);
        pulse_done();

        // Both requesting continuously: grants alternate with a fixed gap
        repeat (6) tick();
        data0 = 40'hA0_A1_A2_A3_A4;
        data1 = 40'hB0_B1_B2_B3_B4;
        gq.push_back('{2'b01, 40'hA0_A1_A2_A3_A4});
        gq.push_back('{2'b10, 40'hB0_B1_B2_B3_B4});
        gq.push_back('{2'b01, 40'hA0_A1_A2_A3_A4});
        gq.push_back('{2'b10, 40'hB0_B1_B2_B3_B4});
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_go(n);
            if (k > 0)
                chk("gap_len", 64'(n), 64'(G));
            tick();
            tick();
            cq.push_back((k % 2 == 0) ? 3'b010 : 3'b100);
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            pulse_done();
        end

        // Transmitter never answers
        repeat (6) tick();
        data0 = 40'hDE_AD_BE_EF_00;
        req0  = 1'b1;
        gq.push_back('{2'b01, 40'hDE_AD_BE_EF_00});
        wait_go(n);
        req0 = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cq.push_back(3'b001);
        hi = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (!tx_go)
                break;
            hi++;
        end
        chk("watchdog_len", 64'(hi), 64'(TO));
        repeat (8) tick();
`else
        hi = 0;
        repeat (1000) @(negedge sys_clk);
        chk("no_watchdog_go", 64'(tx_go), 64'd1);
        chk("no_watchdog_err", 64'(tx_err), 64'd0);
        cq.push_back(3'b010);
        tick();
        pulse_done();
        repeat (8) tick();
`endif

        repeat (4) tick();
        chk("grant_queue_empty", 64'(gq.size()), 64'd0);
        chk("completion_queue_empty", 64'(cq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
